// File: rtl/ceas_pkg.sv
// Shared constants for the clock top: time limits, digit indices,
// seven-segment codes (active-low {dp,g,f,e,d,c,b,a}) and anode patterns.
package ceas_pkg;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] HOUR_MAX = 6'd23;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    DIG_MIN_U = 2'd0,
    DIG_MIN_T = 2'd1,
    DIG_HR_U  = 2'd2,
    DIG_HR_T  = 2'd3
  } digit_e;

  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] anode_pattern(input logic [1:0] sel);
    case (sel)
      2'd0:    return 4'b1110;
      2'd1:    return 4'b1101;
      2'd2:    return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

endpackage

// File: rtl/seg7_mux.sv
// Four-digit multiplexed seven-segment driver: refresh counter, digit
// select, encoding, colon and registered anode/cathode outputs.
module seg7_mux
  import ceas_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] dig_min_u,
  input  logic [3:0] dig_min_t,
  input  logic [3:0] dig_hr_u,
  input  logic [3:0] dig_hr_t,
  input  logic       hr_t_blank,
  input  logic       colon,
  output logic [1:0] sel_q,
  output logic [3:0] anod_q,
  output logic [7:0] catod_q
);

  localparam int RW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [RW-1:0] rc_q, rc_d;
  logic [1:0]    sel_d;
  logic [3:0]    anod_d;
  logic [7:0]    catod_d;
  logic [3:0]    digit;
  logic          wrap;

  always_comb begin
    wrap  = (rc_q == RW'(DIV - 1));
    rc_d  = wrap ? '0 : rc_q + 1'b1;
    sel_d = wrap ? sel_q + 2'd1 : sel_q;
    digit = dig_min_u;
    case (digit_e'(sel_q))
      DIG_MIN_U: digit = dig_min_u;
      DIG_MIN_T: digit = dig_min_t;
      DIG_HR_U:  digit = dig_hr_u;
      DIG_HR_T:  digit = dig_hr_t;
    endcase
    catod_d = seg_encode(digit);
    if (digit_e'(sel_q) == DIG_HR_T && hr_t_blank) catod_d = SEG_BLANK;
    // The colon rides on the dp of the hour-units digit
    if (digit_e'(sel_q) == DIG_HR_U && colon) catod_d[7] = 1'b0;
    anod_d = anode_pattern(sel_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc_q    <= '0;
      sel_q   <= 2'd0;
      anod_q  <= 4'b1111;
      catod_q <= SEG_BLANK;
    end else begin
      rc_q    <= rc_d;
      sel_q   <= sel_d;
      anod_q  <= anod_d;
      catod_q <= catod_d;
    end
  end

endmodule

// File: rtl/ceas_top_param.sv
// Clock top: 1 Hz prescaler, button/UART load arbitration with range check,
// time counters, 12/24h conversion and digit split feeding seg7_mux.
module ceas_top_param
  import ceas_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 400
) (
  input  logic       clk_MHz,
  input  logic       rst,
  input  logic       enable,
  input  logic       load_butoane,
  input  logic [5:0] h_butoane,
  input  logic [5:0] min_butoane,
  input  logic       load_uart,
  input  logic [5:0] h_uart,
  input  logic [5:0] min_uart,
  input  logic       mode_12h,
  output logic [5:0] secunda_q,
  output logic [5:0] minut_q,
  output logic [5:0] ora_q,
  output logic       pm,
  output logic       tick_1hz,
  output logic       load_err,
  output logic [1:0] sel_q,
  output logic [3:0] anod,
  output logic [7:0] catod
);

  localparam int PW  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DIV = CLK_HZ / REFRESH_HZ;

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    secunda_d, minut_d, ora_d;
  logic          load_req, load_ok, tick;
  logic [5:0]    load_h, load_m;

  logic [5:0] disp_h, hr_tens, hr_units, mn_tens, mn_units;
  logic [3:0] hr_tens_q, hr_tens_d, hr_units_q, hr_units_d;
  logic [3:0] mn_tens_q, mn_tens_d, mn_units_q, mn_units_d;
  logic       hr_blank_q, hr_blank_d, colon_q, colon_d;

  always_comb begin
    load_req = load_butoane | load_uart;
    load_h   = load_butoane ? h_butoane   : h_uart;
    load_m   = load_butoane ? min_butoane : min_uart;
    load_ok  = (load_h <= HOUR_MAX) && (load_m <= MIN_MAX);
    tick     = (presc_q == PW'(CLK_HZ - 1));

    presc_d   = tick ? '0 : presc_q + 1'b1;
    secunda_d = secunda_q;
    minut_d   = minut_q;
    ora_d     = ora_q;

    // A load request of either validity suppresses counting for that cycle
    if (load_req) begin
      if (load_ok) begin
        ora_d     = load_h;
        minut_d   = load_m;
        secunda_d = 6'd0;
        presc_d   = '0;
      end else begin
        presc_d = presc_q;
      end
    end else if (tick && enable) begin
      if (secunda_q == SEC_MAX) begin
        secunda_d = 6'd0;
        if (minut_q == MIN_MAX) begin
          minut_d = 6'd0;
          ora_d   = (ora_q == HOUR_MAX) ? 6'd0 : ora_q + 6'd1;
        end else begin
          minut_d = minut_q + 6'd1;
        end
      end else begin
        secunda_d = secunda_q + 6'd1;
      end
    end
  end

  assign tick_1hz = tick;
  assign load_err = rst & load_req & ~load_ok;
  assign pm       = (ora_q >= 6'd12);

  always_comb begin
    disp_h = ora_q;
    if (mode_12h) begin
      if (ora_q == 6'd0 || ora_q == 6'd12) disp_h = 6'd12;
      else if (ora_q > 6'd12)              disp_h = ora_q - 6'd12;
    end
    hr_tens    = disp_h / 6'd10;
    hr_units   = disp_h % 6'd10;
    mn_tens    = minut_q / 6'd10;
    mn_units   = minut_q % 6'd10;
    hr_tens_d  = hr_tens[3:0];
    hr_units_d = hr_units[3:0];
    mn_tens_d  = mn_tens[3:0];
    mn_units_d = mn_units[3:0];
    hr_blank_d = mode_12h && (hr_tens == 6'd0);
    colon_d    = secunda_q[0];
  end

  always_ff @(posedge clk_MHz or negedge rst) begin
    if (!rst) begin
      presc_q    <= '0;
      secunda_q  <= 6'd0;
      minut_q    <= 6'd0;
      ora_q      <= 6'd0;
      hr_tens_q  <= 4'd0;
      hr_units_q <= 4'd0;
      mn_tens_q  <= 4'd0;
      mn_units_q <= 4'd0;
      hr_blank_q <= 1'b0;
      colon_q    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      secunda_q  <= secunda_d;
      minut_q    <= minut_d;
      ora_q      <= ora_d;
      hr_tens_q  <= hr_tens_d;
      hr_units_q <= hr_units_d;
      mn_tens_q  <= mn_tens_d;
      mn_units_q <= mn_units_d;
      hr_blank_q <= hr_blank_d;
      colon_q    <= colon_d;
    end
  end

  seg7_mux #(
    .DIV(DIV)
  ) u_mux (
    .clk        (clk_MHz),
    .rst_n      (rst),
    .dig_min_u  (mn_units_q),
    .dig_min_t  (mn_tens_q),
    .dig_hr_u   (hr_units_q),
    .dig_hr_t   (hr_tens_q),
    .hr_t_blank (hr_blank_q),
    .colon      (colon_q),
    .sel_q      (sel_q),
    .anod_q     (anod),
    .catod_q    (catod)
  );

endmodule

// File: tb/tb_ceas_top_param.sv
// Self-checking bench for ceas_top_param: seconds-of-day reference model
// compared every cycle, plus directed literal checks.
module tb_ceas_top_param;

  localparam int CLK_HZ = 20;
  localparam int REF_HZ = 5;
  localparam int DIV    = CLK_HZ / REF_HZ;

  logic       clk = 1'b0;
  logic       rst, enable, load_butoane, load_uart, mode_12h;
  logic [5:0] h_butoane, min_butoane, h_uart, min_uart;
  logic [5:0] secunda_q, minut_q, ora_q;
  logic       pm, tick_1hz, load_err;
  logic [1:0] sel_q;
  logic [3:0] anod;
  logic [7:0] catod;

  int tests_run    = 0;
  int tests_failed = 0;

  ceas_top_param #(.CLK_HZ(CLK_HZ), .REFRESH_HZ(REF_HZ)) dut (
    .clk_MHz(clk), .rst(rst), .enable(enable),
    .load_butoane(load_butoane), .h_butoane(h_butoane), .min_butoane(min_butoane),
    .load_uart(load_uart), .h_uart(h_uart), .min_uart(min_uart),
    .mode_12h(mode_12h), .secunda_q(secunda_q), .minut_q(minut_q), .ora_q(ora_q),
    .pm(pm), .tick_1hz(tick_1hz), .load_err(load_err), .sel_q(sel_q),
    .anod(anod), .catod(catod)
  );

  always #5 clk = ~clk;

  // Reference model state: time as seconds-of-day, display pipeline snapshots
  int m_tsec = 0, m_presc = 0, m_cyc = 0;
  int disp_t = 0, out_t = 0, out_sel = 0;
  bit disp_mode = 0, out_mode = 0, out_valid = 0;
  int mh, mm;
  bit mreq;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] segsOn(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; default: return 7'h6F;
    endcase
  endfunction

  function automatic logic [7:0] render(input int sel, input int t, input bit mode);
    int h, m, s, dh, d;
    h  = t / 3600;
    m  = (t / 60) % 60;
    s  = t % 60;
    dh = mode ? ((h % 12 == 0) ? 12 : h % 12) : h;
    case (sel)
      0: d = m % 10;
      1: d = m / 10;
      2: d = dh % 10;
      default: d = dh / 10;
    endcase
    if (sel == 3 && mode && d == 0) return 8'hFF;
    return {~(sel == 2 && (s % 2) == 1), ~segsOn(d)};
  endfunction

  function automatic logic [3:0] anodeFor(input int sel);
    case (sel)
      0: return 4'b1110; 1: return 4'b1101; 2: return 4'b1011; default: return 4'b0111;
    endcase
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_tsec = 0; m_presc = 0; m_cyc = 0; disp_t = 0; disp_mode = 0;
      out_valid = 0; out_sel = 0; out_t = 0; out_mode = 0;
    end else begin
      mreq = load_butoane || load_uart;
      mh   = load_butoane ? int'(h_butoane)   : int'(h_uart);
      mm   = load_butoane ? int'(min_butoane) : int'(min_uart);
      out_valid = 1; out_sel = (m_cyc / DIV) % 4; out_t = disp_t; out_mode = disp_mode;
      disp_t = m_tsec; disp_mode = mode_12h;
      if (mreq) begin
        if (mh <= 23 && mm <= 59) begin
          m_tsec = mh * 3600 + mm * 60;
          m_presc = 0;
        end
      end else if (m_presc == CLK_HZ - 1) begin
        m_presc = 0;
        if (enable) m_tsec = (m_tsec + 1) % 86400;
      end else begin
        m_presc++;
      end
      m_cyc++;
    end
  end

  initial forever begin
    @(negedge clk);
    checkOutput("cyc_ora", ora_q, m_tsec / 3600);
    checkOutput("cyc_minut", minut_q, (m_tsec / 60) % 60);
    checkOutput("cyc_secunda", secunda_q, m_tsec % 60);
    checkOutput("cyc_pm", pm, (m_tsec / 3600) >= 12);
    checkOutput("cyc_tick", tick_1hz, rst && m_presc == CLK_HZ - 1);
    checkOutput("cyc_load_err", load_err, rst && (load_butoane || load_uart) &&
                ((load_butoane ? h_butoane : h_uart) > 23 ||
                 (load_butoane ? min_butoane : min_uart) > 59));
    checkOutput("cyc_sel", sel_q, (m_cyc / DIV) % 4);
    checkOutput("cyc_anod", anod, out_valid ? anodeFor(out_sel) : 4'hF);
    checkOutput("cyc_catod", catod, out_valid ? render(out_sel, out_t, out_mode) : 8'hFF);
  end

  task automatic applyStimulus(input bit lb, input int hb, input int mb,
                               input bit lu, input int hu, input int mu,
                               input bit en, input bit md);
    @(posedge clk); #1;
    load_butoane = lb; h_butoane = 6'(hb); min_butoane = 6'(mb);
    load_uart = lu; h_uart = 6'(hu); min_uart = 6'(mu);
    enable = en; mode_12h = md;
  endtask

  task automatic waitAnod(input logic [3:0] pat, input string name);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #2;
      if (anod == pat) found = 1;
    end
    if (!found) checkOutput(name, anod, pat);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0, ticks;
    bit seen;
    rst = 0; enable = 1; mode_12h = 0;
    load_butoane = 0; h_butoane = 0; min_butoane = 0;
    load_uart = 0; h_uart = 0; min_uart = 0;

    repeat (3) @(posedge clk); #2;
    checkOutput("rst_anod", anod, 4'hF);
    checkOutput("rst_catod", catod, 8'hFF);
    checkOutput("rst_ora", ora_q, 0);
    @(posedge clk); #1 rst = 1;

    repeat (5) @(posedge clk); #2;
    checkOutput("sel_e5", sel_q, 1);
    checkOutput("anod_e5", anod, 4'b1101);
    repeat (4) @(posedge clk); #2;
    checkOutput("anod_e9", anod, 4'b1011);
    repeat (4) @(posedge clk); #2;
    checkOutput("anod_e13", anod, 4'b0111);
    repeat (4) @(posedge clk); #2;
    checkOutput("anod_e17", anod, 4'b1110);

    applyStimulus(1, 23, 59, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("load_2359_ora", ora_q, 23);
    checkOutput("load_2359_min", minut_q, 59);
    checkOutput("load_2359_pm", pm, 1);
    repeat (1199) @(posedge clk); #2;
    checkOutput("pre_wrap_sec", secunda_q, 59);
    checkOutput("pre_wrap_pm", pm, 1);
    @(posedge clk); #2;
    checkOutput("wrap_ora", ora_q, 0);
    checkOutput("wrap_min", minut_q, 0);
    checkOutput("wrap_sec", secunda_q, 0);
    checkOutput("wrap_pm", pm, 0);

    applyStimulus(1, 10, 5, 1, 20, 30, 1, 0);
    #1 checkOutput("prio_no_err", load_err, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("prio_ora", ora_q, 10);
    checkOutput("prio_min", minut_q, 5);

    applyStimulus(0, 0, 0, 1, 24, 10, 1, 0);
    #1 checkOutput("bad_hour_err", load_err, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    #1 checkOutput("bad_hour_err_clr", load_err, 0);
    checkOutput("bad_hour_ora", ora_q, 10);
    applyStimulus(0, 0, 0, 1, 5, 60, 1, 0);
    #1 checkOutput("bad_min_err", load_err, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("bad_min_ora", ora_q, 10);
    checkOutput("bad_min_min", minut_q, 5);

    applyStimulus(1, 0, 7, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    repeat (3) @(posedge clk);
    waitAnod(4'b0111, "wait_h12_tens");
    checkOutput("h12_tens", catod, 8'hF9);
    waitAnod(4'b1011, "wait_h12_units");
    checkOutput("h12_units", catod[6:0], 7'h24);
    checkOutput("h12_pm", pm, 0);

    applyStimulus(1, 13, 45, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    repeat (3) @(posedge clk);
    waitAnod(4'b0111, "wait_h1_tens");
    checkOutput("h1_tens_blank", catod, 8'hFF);
    waitAnod(4'b1101, "wait_m4_tens");
    checkOutput("m45_tens", catod, 8'h99);
    waitAnod(4'b1011, "wait_h1_units");
    checkOutput("h1_units", catod[6:0], 7'h79);
    checkOutput("h13_pm", pm, 1);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    s0 = secunda_q; ticks = 0;
    for (int i = 0; i < 3 * CLK_HZ; i++) begin
      @(posedge clk); #2;
      if (tick_1hz) ticks++;
    end
    checkOutput("frozen_ticks", ticks, 3);
    checkOutput("frozen_sec", secunda_q, s0);

    seen = 0;
    for (int i = 0; i < 2 * CLK_HZ && !seen; i++) begin
      @(posedge clk); #2;
      if (tick_1hz) seen = 1;
    end
    if (!seen) checkOutput("wait_tick", tick_1hz, 1);
    load_butoane = 1; h_butoane = 6'd5; min_butoane = 6'd20; enable = 1;
    @(posedge clk); #1 load_butoane = 0;
    checkOutput("tickload_ora", ora_q, 5);
    checkOutput("tickload_min", minut_q, 20);
    checkOutput("tickload_sec", secunda_q, 0);
    checkOutput("tickload_tick", tick_1hz, 0);

    applyStimulus(1, 7, 7, 0, 0, 0, 1, 0);
    #2 rst = 0;
    #1 checkOutput("midrst_ora", ora_q, 0);
    checkOutput("midrst_anod", anod, 4'hF);
    @(posedge clk); #1 rst = 1; load_butoane = 0;
    #2 checkOutput("postrst_ora", ora_q, 0);
    checkOutput("postrst_min", minut_q, 0);
    checkOutput("postrst_catod", catod, 8'hFF);

    repeat (6) @(posedge clk); #2;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ceas_top_param.md
# ceas_top_param

Parametrised next-generation clock top: one clock domain with tick enables instead of derived clocks, arbitrated time load from buttons or UART with range checking, selectable 12/24-hour display, and a 4-digit multiplexed seven-segment driver. It sits between the input front-ends (button debouncer, UART command decoder) and the board's anode/cathode pins.

## Interface
- CLK_HZ, 100_000_000, input clock frequency; one `tick_1hz` every CLK_HZ cycles.
- REFRESH_HZ, 400, digit-switch rate; CLK_HZ/REFRESH_HZ must be an integer ≥ 2.
- clk_MHz  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  1 = time advances on `tick_1hz`; 0 = time frozen (prescaler keeps running).
- load_butoane  in  1  button load request, highest priority.
- h_butoane, min_butoane  in  6 each  button-set hour/minute.
- load_uart  in  1  UART load request.
- h_uart, min_uart  in  6 each  UART-set hour/minute.
- mode_12h  in  1  0 = 24-hour display, 1 = 12-hour display.
- secunda_q, minut_q, ora_q  out  6 each  binary time (ora_q always 0..23).
- pm  out  1  1 when ora_q ≥ 12.
- tick_1hz  out  1  one-cycle pulse per second.
- load_err  out  1  one-cycle pulse on rejected load.
- sel_q  out  2  active digit index.
- anod  out  4  active-low anode select.
- catod  out  8  active-low segments {dp,g,f,e,d,c,b,a}.

## Operation
- Prescaler 0..CLK_HZ-1; `tick_1hz`=1 in the cycle count==CLK_HZ-1, then wraps to 0.
- Load arbitration per cycle: load_butoane=1 selects button values, else load_uart=1 selects UART values, else no load. No latches; selection is combinational into a registered update.
- Valid load (h ≤ 23 and min ≤ 59): next edge ora_q=h, minut_q=min, secunda_q=0, prescaler=0. Load overrides a coincident tick. Applies regardless of `enable`.
- Invalid load: time and prescaler unchanged, load_err=1 for that cycle. Held load reasserts every cycle (level-sensitive).
- Count on tick_1hz & enable & no load: secunda 59→0 with carry; minut 59→0 with carry; ora 23→0.
- Display hour: 24h mode = ora_q; 12h mode = 12 if ora_q∈{0,12}, ora_q-12 if ora_q>12, else ora_q. Digits via /10, %10 on 6-bit values; digit registers update every cycle.
- Blanking: hour tens digit blank in 12h mode when zero.
- Mux: refresh counter period CLK_HZ/REFRESH_HZ; on wrap sel_q increments 3→0. sel 0 = minute units (anod 1110), 1 = minute tens (1101), 2 = hour units (1011), 3 = hour tens (0111).
- Colon: dp segment lit (catod[7]=0) only when sel_q=2 and secunda_q[0]=1; otherwise catod[7]=1.
- Blank digit: catod = 8'hFF.

## Timing
- Reset values: time 0:00:00, prescaler 0, refresh counter 0, sel_q=0, pm=0, tick_1hz=0, load_err=0, anod=4'b1111, catod=8'hFF.
- Load → ora_q/minut_q/secunda_q: 1 cycle. Time regs → digit regs: 1 cycle. sel_q/digits → anod/catod: 1 cycle (registered outputs).
- First tick_1hz after reset release or valid load: CLK_HZ cycles later.
- Mode change affects catod within 2 cycles; no effect on ora_q.
- Reset assertion mid-count or mid-load returns everything to reset values immediately; pending load is discarded.

## Structure
- Package `ceas_pkg`: seven-seg codes for 0-9 and BLANK, anode patterns per digit index, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
- Sub-module `seg7_mux`: refresh counter, sel_q, digit select, encoding, dp and registered anod/catod. Top keeps prescaler, arbitration, time counters, 12h conversion and digit split.

## Test plan
- Reset with CLK_HZ=20, REFRESH_HZ=5 → anod=1111, catod=FF, time 00:00:00; after release sel_q cycles 0..3 every 4 cycles, anod 1110/1101/1011/0111.
- Button load 23:59 then 60 ticks with enable=1 → time 00:00:00, pm 1→0 at wrap.
- load_butoane=1 (h=10,min=05) and load_uart=1 (h=20,min=30) same cycle → time 10:05:00, no load_err.
- UART load h=24,min=10 → load_err pulse 1 cycle, time unchanged; min=60 → same.
- mode_12h=1, load 00:07 → hour digits "12"; load 13:45 → "1" with blank tens (catod FF on sel 3), pm=1.
- enable=0 for 3 ticks → secunda_q frozen, tick_1hz still pulses; load during tick cycle → loaded value, secunda_q=0.
